// File: rtl/data_path.sv
// Single-bus 32-bit processor datapath: register file, special registers,
// opcode-driven ALU with 64-bit Z, branch-condition flip-flop and I/O ports.
module data_path (
  input  logic        Clock,
  input  logic        clear,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        Zhighout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        MDRout,
  input  logic        In_Portout,
  input  logic        Cout,
  input  logic        Baout,
  input  logic        MARin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        Zin_high,
  input  logic        Zin_low,
  input  logic        r_in,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        Write,
  input  logic        ConIn,
  input  logic        inPortenable,
  input  logic        outPortenable,
  input  logic [31:0] Mdatain,
  input  logic [31:0] inPort_input,
  output logic [4:0]  operation,
  output logic [31:0] outport_out
);

  typedef enum logic [4:0] {
    OP_LDW  = 5'b00000, OP_LDWI = 5'b00001, OP_STW  = 5'b00010,
    OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_SHR  = 5'b00101,
    OP_SHL  = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000,
    OP_AND  = 5'b01001, OP_OR   = 5'b01010, OP_ADDI = 5'b01011,
    OP_ANDI = 5'b01100, OP_ORI  = 5'b01101, OP_MUL  = 5'b01110,
    OP_DIV  = 5'b01111, OP_NEG  = 5'b10000, OP_NOT  = 5'b10001,
    OP_BR   = 5'b10010
  } op_e;

  logic [31:0] regs [16];
  logic [31:0] pc, ir, y, hi, lo, mar, mdr, in_port, out_port;
  logic [63:0] z;
  logic        con;

  logic [31:0] bus;
  logic [3:0]  sel;
  logic [31:0] reg_out;
  logic [31:0] c_sext;
  op_e         opcode;
  logic [63:0] alu_res;
  logic        con_next;
  logic        unused_sinks;

  assign opcode = op_e'(ir[31:27]);
  assign sel    = ({4{Gra}} & ir[26:23]) | ({4{Grb}} & ir[22:19]) | ({4{Grc}} & ir[18:15]);
  assign reg_out = (sel == 4'd0) ? '0 : regs[sel];
  assign c_sext  = {{13{ir[18]}}, ir[18:0]};

  always_comb begin
    bus = '0;
    if      (Baout)      bus = reg_out;
    else if (PCout)      bus = pc;
    else if (Zhighout)   bus = z[63:32];
    else if (Zlowout)    bus = z[31:0];
    else if (HIout)      bus = hi;
    else if (LOout)      bus = lo;
    else if (MDRout)     bus = mdr;
    else if (In_Portout) bus = in_port;
    else if (Cout)       bus = c_sext;
  end

  // ALU: A is Y, B is the bus.
  logic [4:0]         sh;
  logic [63:0]        rot_r, rot_l;
  logic signed [63:0] prod;
  logic signed [31:0] quo, rem;

  assign sh    = bus[4:0];
  assign rot_r = {y, y} >> sh;
  assign rot_l = {y, y} << sh;
  assign prod  = $signed({{32{y[31]}}, y}) * $signed({{32{bus[31]}}, bus});
  assign quo   = (bus == '0) ? '0 : $signed(y) / $signed(bus);
  assign rem   = (bus == '0) ? '0 : $signed(y) % $signed(bus);

  always_comb begin
    alu_res = {32'b0, y + bus};
    if (IncPC) begin
      alu_res = {32'b0, bus + 32'd1};
    end else begin
      case (opcode)
        OP_SUB:          alu_res = {32'b0, y - bus};
        OP_SHR:          alu_res = {32'b0, y >> sh};
        OP_SHL:          alu_res = {32'b0, y << sh};
        OP_ROR:          alu_res = {32'b0, rot_r[31:0]};
        OP_ROL:          alu_res = {32'b0, rot_l[63:32]};
        OP_AND, OP_ANDI: alu_res = {32'b0, y & bus};
        OP_OR, OP_ORI:   alu_res = {32'b0, y | bus};
        OP_MUL:          alu_res = prod;
        OP_DIV:          alu_res = (bus == '0) ? {y, 32'hFFFF_FFFF} : {rem, quo};
        OP_NEG:          alu_res = {32'b0, 32'd0 - bus};
        OP_NOT:          alu_res = {32'b0, ~bus};
        default:         alu_res = {32'b0, y + bus};
      endcase
    end
  end

  always_comb begin
    con_next = 1'b0;
    case (ir[20:19])
      2'b00: con_next = (bus == '0);
      2'b01: con_next = (bus != '0);
      2'b10: con_next = !bus[31] && (bus != '0);
      2'b11: con_next = bus[31];
      default: con_next = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
      pc <= '0; ir <= '0; y <= '0; z <= '0; hi <= '0; lo <= '0;
      mar <= '0; mdr <= '0; in_port <= '0; out_port <= '0; con <= 1'b0;
    end else begin
      if (r_in)          regs[sel]  <= bus;
      if (PCin)          pc         <= bus;
      if (IRin)          ir         <= bus;
      if (Yin)           y          <= bus;
      if (HIin)          hi         <= bus;
      if (LOin)          lo         <= bus;
      if (MARin)         mar        <= bus;
      if (MDRin)         mdr        <= Read ? Mdatain : bus;
      if (Zin_high)      z[63:32]   <= alu_res[63:32];
      if (Zin_low)       z[31:0]    <= alu_res[31:0];
      if (ConIn)         con        <= con_next;
      if (inPortenable)  in_port    <= inPort_input;
      if (outPortenable) out_port   <= bus;
    end
  end

  assign operation   = ir[31:27];
  assign outport_out = out_port;

  // MAR, CON and Write feed logic outside this block only.
  assign unused_sinks = ^{mar, con, Write};

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: stimulus queues expected register values,
// a negedge monitor pops and compares them.
module tb_data_path;

  logic        Clock, clear;
  logic        PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Baout;
  logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_high, Zin_low, r_in;
  logic        Gra, Grb, Grc, IncPC, Read, Write, ConIn, inPortenable, outPortenable;
  logic [31:0] Mdatain, inPort_input;
  logic [4:0]  operation;
  logic [31:0] outport_out;

  data_path dut (
    .Clock(Clock), .clear(clear),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .In_Portout(In_Portout), .Cout(Cout), .Baout(Baout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
    .LOin(LOin), .Zin_high(Zin_high), .Zin_low(Zin_low), .r_in(r_in),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write),
    .ConIn(ConIn), .inPortenable(inPortenable), .outPortenable(outPortenable),
    .Mdatain(Mdatain), .inPort_input(inPort_input),
    .operation(operation), .outport_out(outport_out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef enum {P_OP, P_OUT, P_MAR, P_PC, P_IR, P_Y, P_ZLO, P_ZHI, P_CON, P_R1} probe_e;
  typedef struct {
    probe_e      k;
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] probe(input probe_e k);
    case (k)
      P_OP:    return {27'b0, operation};
      P_OUT:   return outport_out;
      P_MAR:   return dut.mar;
      P_PC:    return dut.pc;
      P_IR:    return dut.ir;
      P_Y:     return dut.y;
      P_ZLO:   return dut.z[31:0];
      P_ZHI:   return dut.z[63:32];
      P_CON:   return {31'b0, dut.con};
      P_R1:    return dut.regs[1];
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  always @(negedge Clock) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = probe(e.k);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_val(input probe_e k, input string name, input logic [31:0] v);
    exp_t e;
    e.k = k; e.name = name; e.exp = v;
    q.push_back(e);
  endtask

  task automatic idle();
    {PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Baout} = '0;
    {MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_high, Zin_low, r_in} = '0;
    {Gra, Grb, Grc, IncPC, Read, Write, ConIn, inPortenable, outPortenable} = '0;
    Mdatain = '0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    step();
  endtask

  task automatic load_ir(input logic [31:0] v);
    load_mdr(v);
    MDRout = 1'b1; IRin = 1'b1;
    step();
  endtask

  initial begin
    int guard;
    idle();
    inPort_input = '0;
    clear = 1'b0;
    #1;
    expect_val(P_OP,  "reset_op",  32'd0);
    expect_val(P_OUT, "reset_out", 32'd0);
    repeat (2) @(posedge Clock);
    #1;
    clear = 1'b1;

    // Fetch
    PCout = 1; MARin = 1; IncPC = 1; Zin_high = 1; Zin_low = 1;
    step();
    expect_val(P_MAR, "fetch_mar", 32'd0);
    expect_val(P_ZLO, "fetch_zlo", 32'd1);
    expect_val(P_ZHI, "fetch_zhi", 32'd0);
    Zlowout = 1; PCin = 1;
    step();
    expect_val(P_PC, "fetch_pc", 32'd1);
    load_ir(32'h0080_0055);
    expect_val(P_IR, "fetch_ir", 32'h0080_0055);
    expect_val(P_OP, "fetch_op", 32'd0);

    // ldw R1,0x55(R0)
    Grb = 1; Baout = 1; Yin = 1;
    step();
    expect_val(P_Y, "ldw_y", 32'd0);
    Cout = 1; Zin_low = 1; Zin_high = 1;
    step();
    expect_val(P_ZLO, "ldw_zlo", 32'h55);
    Zlowout = 1; MARin = 1;
    step();
    expect_val(P_MAR, "ldw_mar", 32'h55);
    load_mdr(32'h1234);
    MDRout = 1; Gra = 1; r_in = 1;
    step();
    expect_val(P_R1, "ldw_r1", 32'h1234);
    Gra = 1; Baout = 1; outPortenable = 1;
    step();
    expect_val(P_OUT, "ldw_out_r1", 32'h1234);

    // add R4,R2,R3
    load_ir(32'h1A11_8000);
    expect_val(P_OP, "add_op", 32'd3);
    load_mdr(32'd5);
    MDRout = 1; Grb = 1; r_in = 1;
    step();
    load_mdr(32'd7);
    MDRout = 1; Grc = 1; r_in = 1;
    step();
    Grb = 1; Baout = 1; Yin = 1;
    step();
    Grc = 1; Baout = 1; Zin_low = 1; Zin_high = 1;
    step();
    expect_val(P_ZLO, "add_zlo", 32'd12);
    expect_val(P_ZHI, "add_zhi", 32'd0);
    Zlowout = 1; Gra = 1; r_in = 1;
    step();
    Gra = 1; Baout = 1; outPortenable = 1;
    step();
    expect_val(P_OUT, "add_out_r4", 32'd12);

    // mul -3 * 4
    load_ir(32'h7000_0000);
    load_mdr(32'hFFFF_FFFD);
    MDRout = 1; Yin = 1;
    step();
    load_mdr(32'd4);
    MDRout = 1; Zin_high = 1; Zin_low = 1;
    step();
    expect_val(P_ZHI, "mul_zhi", 32'hFFFF_FFFF);
    expect_val(P_ZLO, "mul_zlo", 32'hFFFF_FFF4);
    Zhighout = 1; outPortenable = 1;
    step();
    expect_val(P_OUT, "mul_out_zhi", 32'hFFFF_FFFF);

    // div 17 / 5, then divide by zero (idle bus is 0)
    load_ir(32'h7800_0000);
    load_mdr(32'd17);
    MDRout = 1; Yin = 1;
    step();
    load_mdr(32'd5);
    MDRout = 1; Zin_high = 1; Zin_low = 1;
    step();
    expect_val(P_ZLO, "div_quo", 32'd3);
    expect_val(P_ZHI, "div_rem", 32'd2);
    Zin_high = 1; Zin_low = 1;
    step();
    expect_val(P_ZLO, "div0_lo", 32'hFFFF_FFFF);
    expect_val(P_ZHI, "div0_hi", 32'd17);

    // ror 0x80000001 by 1
    load_ir(32'h3800_0000);
    load_mdr(32'h8000_0001);
    MDRout = 1; Yin = 1;
    step();
    load_mdr(32'd1);
    MDRout = 1; Zin_high = 1; Zin_low = 1;
    step();
    expect_val(P_ZLO, "ror_zlo", 32'hC000_0000);
    expect_val(P_ZHI, "ror_zhi", 32'd0);

    // Branch conditions
    load_ir(32'h0008_0000);
    load_mdr(32'h10);
    MDRout = 1; ConIn = 1;
    step();
    expect_val(P_CON, "con_ne_true", 32'd1);
    ConIn = 1;
    step();
    expect_val(P_CON, "con_ne_zero", 32'd0);
    load_ir(32'h0018_0000);
    load_mdr(32'h8000_0000);
    MDRout = 1; ConIn = 1;
    step();
    expect_val(P_CON, "con_neg_true", 32'd1);
    load_mdr(32'h7FFF_FFFF);
    MDRout = 1; ConIn = 1;
    step();
    expect_val(P_CON, "con_neg_false", 32'd0);

    // Ports
    load_mdr(32'hA5);
    MDRout = 1; outPortenable = 1;
    step();
    expect_val(P_OUT, "outport_a5", 32'hA5);
    inPort_input = 32'h0000_DEAD; inPortenable = 1;
    step();
    In_Portout = 1; outPortenable = 1;
    step();
    expect_val(P_OUT, "inport_to_out", 32'h0000_DEAD);

    // Mid-run asynchronous reset
    load_ir(32'hF800_0000);
    expect_val(P_OP, "pre_reset_op", 32'd31);
    step();
    clear = 1'b0;
    #1;
    expect_val(P_OP,  "async_op",  32'd0);
    expect_val(P_OUT, "async_out", 32'd0);
    expect_val(P_PC,  "async_pc",  32'd0);
    expect_val(P_R1,  "async_r1",  32'd0);
    expect_val(P_ZHI, "async_zhi", 32'd0);
    In_Portout = 1; outPortenable = 1; inPortenable = 1;
    step();
    expect_val(P_OUT, "reset_holds_out", 32'd0);
    clear = 1'b1;

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge Clock);
      guard++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries pending, expected 0", q.size());
    end
    @(negedge Clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
